// File: rtl/demux14_pkg.sv
// Shared constants and types for the 1-to-4 streaming demultiplexer.
package demux14_pkg;
    localparam int LANES = 4;
    localparam int SEL_W = 2;
    localparam int DEPTH = 2;

    typedef logic [SEL_W-1:0] lane_idx_t;
    typedef logic [1:0]       cnt_t;
endpackage

// File: rtl/demux14_lane.sv
// One output lane: a 2-entry FIFO with 1-bit wrapping pointers and a 0..2 count.
module demux14_lane #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_vld,
    output logic [1:0]       o_cnt
);
    import demux14_pkg::*;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    cnt_t             r_cnt;
    logic             w_pop;

    // A pop request against an empty lane is simply ignored.
    assign w_pop  = i_pop & o_vld;
    assign o_vld  = (r_cnt != 2'd0);
    assign o_head = o_vld ? r_mem[r_rd_ptr] : '0;
    assign o_cnt  = r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_cnt    <= 2'd0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: rtl/demux14.sv
// Routes each accepted input word to lane {s1,s0}; every lane buffers independently.
module demux14 #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             s0,
    input  logic             s1,
    input  logic             in_vld,
    output logic             in_rdy,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             vld0,
    output logic             vld1,
    output logic             vld2,
    output logic             vld3,
    input  logic             rdy0,
    input  logic             rdy1,
    input  logic             rdy2,
    input  logic             rdy3,
    output logic             busy
);
    import demux14_pkg::*;

    lane_idx_t        w_sel;
    cnt_t             w_cnt  [LANES];
    logic [WIDTH-1:0] w_head [LANES];
    logic [LANES-1:0] w_vld;
    logic [LANES-1:0] w_rdy;
    logic [LANES-1:0] w_push;

    assign w_sel  = {s1, s0};
    // Readiness looks only at the addressed lane's fill level, never at in_vld or pops.
    assign in_rdy = (w_cnt[w_sel] != cnt_t'(DEPTH));
    assign w_rdy  = {rdy3, rdy2, rdy1, rdy0};

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_push[g] = in_vld & in_rdy & (w_sel == lane_idx_t'(g));
        demux14_lane #(.WIDTH(WIDTH)) u_lane (
            .i_clk  (clk),
            .i_rst  (rst),
            .i_push (w_push[g]),
            .i_pop  (w_rdy[g]),
            .i_data (in),
            .o_head (w_head[g]),
            .o_vld  (w_vld[g]),
            .o_cnt  (w_cnt[g])
        );
    end

    assign out0 = w_head[0];
    assign out1 = w_head[1];
    assign out2 = w_head[2];
    assign out3 = w_head[3];
    assign vld0 = w_vld[0];
    assign vld1 = w_vld[1];
    assign vld2 = w_vld[2];
    assign vld3 = w_vld[3];
    assign busy = |w_vld;
endmodule

// File: doc/demux14.md
# demux14

Streaming 1-to-4 demultiplexer for the TOY benchmark set; it performs the inverse of the 4:1 selector. Each input word is routed by the two select bits to one of four output lanes. Each lane holds a 2-entry FIFO, so a stalled lane does not lose data and the other lanes keep draining. It sits between a single producer and four independent consumers, all on one clock.

## Interface
Parameters:
- WIDTH, 1, data bits per word (in and each lane output).
- DEPTH, 2, entries per lane FIFO; fixed at 2 for this revision.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in  input  WIDTH  input word.
- s0  input  1  select bit 0 (lane index LSB).
- s1  input  1  select bit 1 (lane index MSB).
- in_vld  input  1  producer offers in/s0/s1 this cycle.
- in_rdy  output  1  selected lane can accept the word this cycle.
- out0..out3  output  WIDTH each  head word of lanes 0..3.
- vld0..vld3  output  1 each  lane N FIFO non-empty.
- rdy0..rdy3  input  1 each  consumer N pops the head this cycle.
- busy  output  1  any lane non-empty.

## Operation
- Lane index L = {s1,s0}: 00→lane0, 01→lane1, 10→lane2, 11→lane3.
- in_rdy = (count[L] != DEPTH). It is combinational from s0/s1 and the lane counts, and it does not depend on in_vld or any rdyN.
- Push: at a rising edge with in_vld & in_rdy, `in` is written to the tail of lane L and count[L] increments.
- Pop: at a rising edge with vldN & rdyN, the head of lane N is removed and count[N] decrements. rdyN while vldN is low is ignored.
- Push and pop on the same lane in the same cycle:
  - Allowed when count is 1. Count stays 1 and the new word becomes the head.
  - Allowed when count is 0. This case cannot happen, because there is no pop from an empty lane; count goes to 1.
  - A full lane never pushes in a cycle where in_rdy is low, even if that lane is popped in the same cycle. There is no full-pass-through.
- A push to lane A and pops on any set of other lanes in the same cycle are fully independent.
- vldN = (count[N] != 0).
- outN = head word when vldN is high, and all-zero when vldN is low.
- busy = OR of vld0..vld3.
- Lane FIFO pointers: 1-bit read and write pointers with wrap-around at DEPTH. count is 0..2, held in 2 bits.
- Word order within a lane is strict FIFO. There is no ordering guarantee across lanes.

## Timing
- Reset (async assert, sync-safe deassert handled upstream):
  - all counts and pointers go to 0;
  - vld0..vld3 = 0, out0..out3 = 0, busy = 0;
  - in_rdy = 1 for every select value.
- Latency: a word accepted at edge k appears on outL with vldL=1 after edge k (cycle k+1) if lane L was empty. Otherwise it appears after the preceding words drain.
- Throughput: one word per cycle into any lane whose consumer holds rdyN=1 continuously.
- Reset mid-operation: buffered words are discarded immediately, with no drain, and outputs go to their reset values within the reset assertion.
- Producer rule: in, s0 and s1 must be held stable while in_vld is high and in_rdy is low. Changing the select while stalled is legal but retargets the offer.

## Structure
- Package demux14_pkg holds:
  - LANES = 4, SEL_W = 2, DEPTH = 2;
  - typedef lane_idx_t (SEL_W bits);
  - typedef cnt_t (2 bits).
- Sub-module demux14_lane: one WIDTH×DEPTH FIFO with push, pop, count, head and valid. It is instantiated four times by a generate loop.
- The top level contains only the select decode, the in_rdy mux and the busy OR.

## Test plan
- Reset then idle: all vldN=0, outN=0, busy=0, in_rdy=1 for all {s1,s0}.
- Route: push in=1 with {s1,s0}=10, rdy all 0 → next cycle vld2=1, out2=1, and all other lanes are empty.
- Fill and stall: push 1 then 0 to lane 1 with rdy1=0 → after 2 edges count=2 and in_rdy=0 for s=01, while in_rdy=1 for s=00. Then rdy1=1 → out1 shows 1, then 0, then vld1=0.
- Simultaneous: lane 3 holds one word. Push to lane 3 and pop lane 3 in the same edge → vld3 stays 1 and out3 equals the new word. Concurrent pops on lanes 0 and 2 complete in that same edge.
- Streaming: rdy all 1, 16 consecutive words cycling {s1,s0}=00,01,10,11 → in_rdy is never low, and each lane receives its 4 words in order, one cycle after acceptance.
- Reset mid-operation: assert rst with lanes 0 and 3 full → vld0 and vld3 drop asynchronously, and after release all lanes are empty with in_rdy=1.
